// File: rtl/registers.sv
`default_nettype none
// ============================================================================
//  Module      : registers
//  Description : Bank of eight DATA_W-bit registers with one synchronous
//                write port and one combinational, enable-gated read port.
//                Every register is also exposed continuously on r0..r7.
//
//  Ports
//    clk       in   1       single clock, all updates on rising edge
//    rst_n     in   1       synchronous active-low reset, clears R0..R7
//    s_in      in   3       write register select
//    s_out     in   3       read register select
//    d_in      in   DATA_W  write data
//    write_en  in   1       active-high write enable
//    out_en    in   1       active-high read enable (d_out = 0 when low)
//    d_out     out  DATA_W  contents of R[s_out] when out_en, else zero
//    r0..r7    out  DATA_W  continuous view of R0..R7
//
//  Revision    : 1.0 - initial release
// ============================================================================
module registers #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [2:0]        s_in,
    input  logic [2:0]        s_out,
    input  logic [DATA_W-1:0] d_in,
    input  logic              write_en,
    input  logic              out_en,
    output logic [DATA_W-1:0] d_out,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7
);

    // Register count is tied to the 3-bit selects, so it is not a parameter.
    localparam int C_NUM_REGS = 8;

    logic [DATA_W-1:0] r_regs [C_NUM_REGS];

    // Reset takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < C_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (write_en) begin
            r_regs[s_in] <= d_in;
        end
    end

    // Read path is taken from the register outputs only: no bypass of d_in,
    // so a same-cycle write becomes visible just after the edge.
    assign d_out = out_en ? r_regs[s_out] : '0;

    assign r0 = r_regs[0];
    assign r1 = r_regs[1];
    assign r2 = r_regs[2];
    assign r3 = r_regs[3];
    assign r4 = r_regs[4];
    assign r5 = r_regs[5];
    assign r6 = r_regs[6];
    assign r7 = r_regs[7];

endmodule
`default_nettype wire

// File: tb/tb_registers.sv
`default_nettype none
// ============================================================================
//  Module      : tb_registers
//  Description : Self-checking bench for registers. Directed scenarios
//                followed by randomized traffic, all compared against an
//                array-based reference model of the register bank.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_registers;

    logic       clk;
    logic       rst_n;
    logic [2:0] s_in;
    logic [2:0] s_out;
    logic [7:0] d_in;
    logic       write_en;
    logic       out_en;
    logic [7:0] d_out;
    logic [7:0] ro [8];

    int errors = 0;
    int checks = 0;

    // Reference model: the eight register values.
    logic [7:0] model [8];

    registers #(.DATA_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_in     (s_in),
        .s_out    (s_out),
        .d_in     (d_in),
        .write_en (write_en),
        .out_en   (out_en),
        .d_out    (d_out),
        .r0       (ro[0]),
        .r1       (ro[1]),
        .r2       (ro[2]),
        .r3       (ro[3]),
        .r4       (ro[4]),
        .r5       (ro[5]),
        .r6       (ro[6]),
        .r7       (ro[7])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_dout();
        return out_en ? model[s_out] : 8'h00;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s r%0d", tag, i), ro[i], model[i]);
        end
        chk($sformatf("%s d_out", tag), d_out, exp_dout());
    endtask

    // One rising edge; the model applies the rules to the inputs present
    // at that edge, and outputs are sampled 1 time unit later.
    task automatic tick();
        logic [7:0] nxt [8];
        for (int i = 0; i < 8; i++) nxt[i] = model[i];
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) nxt[i] = 8'h00;
        end else if (write_en) begin
            nxt[s_in] = d_in;
        end
        @(posedge clk);
        for (int i = 0; i < 8; i++) model[i] = nxt[i];
        #1;
    endtask

    task automatic write_reg(input logic [2:0] sel, input logic [7:0] val);
        write_en = 1'b1;
        s_in     = sel;
        d_in     = val;
        tick();
    endtask

    initial begin
        for (int i = 0; i < 8; i++) model[i] = 8'hxx;
        rst_n = 1'b0; s_in = 3'd0; s_out = 3'd0; d_in = 8'h00;
        write_en = 1'b0; out_en = 1'b0;
        @(negedge clk);
        tick();
        tick();

        // Reset state, d_out zero with out_en either way
        check_all("reset oe0");
        out_en = 1'b1; s_out = 3'd4; #1;
        check_all("reset oe1");

        // Four successive writes
        rst_n = 1'b1; out_en = 1'b0;
        write_reg(3'd0, 8'hAA);
        write_reg(3'd1, 8'hBB);
        write_reg(3'd2, 8'hCC);
        write_reg(3'd3, 8'hDD);
        write_en = 1'b0;
        check_all("writes");
        chk("r3 literal", ro[3], 8'hDD);

        // Combinational read, no latency
        out_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_out = 3'(i); #1;
            chk($sformatf("read s_out=%0d", i), d_out, model[i]);
        end
        chk("read AA literal", model[0], 8'hAA);

        // Output disabled
        out_en = 1'b0;
        for (int i = 0; i < 8; i++) begin
            s_out = 3'(i); #1;
            chk($sformatf("oe0 s_out=%0d", i), d_out, 8'h00);
        end
        check_all("oe0 regs");

        // write_en low: registers hold while data/select change
        write_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_in = 3'(i + 2); d_in = 8'(8'h11 * (i + 1));
            tick();
        end
        check_all("hold");

        // Reset between edges takes effect only at the edge, beating a write
        @(negedge clk);
        rst_n = 1'b0; write_en = 1'b1; s_in = 3'd5; d_in = 8'h5A; out_en = 1'b1; s_out = 3'd0;
        #1;
        chk("async-free r0", ro[0], 8'hAA);
        check_all("pre-reset-edge");
        tick();
        check_all("reset beats write");
        chk("r5 after reset", ro[5], 8'h00);
        rst_n = 1'b1; #1;
        chk("r5 at release", ro[5], 8'h00);
        tick();
        chk("r5 after release", ro[5], 8'h5A);
        check_all("release write");

        // Same-register read/write, no bypass
        write_reg(3'd7, 8'h81);
        s_in = 3'd7; s_out = 3'd7; out_en = 1'b1; d_in = 8'h3C; write_en = 1'b1; #1;
        chk("r7 before edge", d_out, 8'h81);
        tick();
        chk("r7 after edge", d_out, 8'h3C);
        write_en = 1'b0;

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            rst_n    = ($urandom_range(0, 31) != 0);
            write_en = $urandom_range(0, 1);
            out_en   = $urandom_range(0, 1);
            s_in     = 3'($urandom_range(0, 7));
            s_out    = 3'($urandom_range(0, 7));
            d_in     = 8'($urandom);
            #1;
            chk("rand pre-edge d_out", d_out, exp_dout());
            tick();
            check_all("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
